// File: rtl/lcd_spi_tx.sv
// 3-wire SPI transmitter for the LCD panel: runs the RESX power-up sequence, then shifts
// valid/ready words out MSB first. CSX is held low across a burst until a LAST word completes.
module lcd_spi_tx #(
  parameter int unsigned DATA_W    = 18,
  parameter int unsigned CLK_DIV   = 1,
  parameter int unsigned DC_BIT    = 0,
  parameter int unsigned RESX_LOW  = 4,
  parameter int unsigned RESX_WAIT = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              INIT,
  input  logic              TX_VALID,
  output logic              TX_READY,
  input  logic [DATA_W-1:0] TX_DATA,
  input  logic              TX_DC,
  input  logic              TX_LAST,
  output logic              CSX,
  output logic              SCL,
  output logic              SDA,
  output logic              RESX,
  output logic              BUSY
);

  localparam int unsigned NB   = DATA_W + DC_BIT;
  localparam int unsigned BW   = $clog2(NB + 1);
  localparam int unsigned DW   = $clog2(CLK_DIV + 1);
  localparam int unsigned RMAX = (RESX_LOW > RESX_WAIT) ? RESX_LOW : RESX_WAIT;
  localparam int unsigned RW   = $clog2(RMAX + 1);

  typedef enum logic [2:0] {StRstLo, StRstWait, StIdle, StShift, StHold} state_e;

  state_e          state_q;
  logic [NB-1:0]   sreg_q;
  logic [BW-1:0]   bcnt_q;
  logic [DW-1:0]   dcnt_q;
  logic [RW-1:0]   rcnt_q;
  logic            last_q;
  logic            ready_q;
  logic [NB-1:0]   frame;
  logic [NB-1:0]   sreg_nx;
  logic            accept;

  // Truncating the concatenation drops TX_DC when the D/C bit is not in use.
  assign frame    = NB'({TX_DC, TX_DATA});
  assign sreg_nx  = sreg_q << 1;
  assign TX_READY = ready_q & ~INIT;
  assign accept   = TX_VALID & TX_READY;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StRstLo;
      RESX    <= 1'b0;
      CSX     <= 1'b1;
      SCL     <= 1'b0;
      SDA     <= 1'b0;
      ready_q <= 1'b0;
      BUSY    <= 1'b1;
      rcnt_q  <= '0;
      dcnt_q  <= '0;
      bcnt_q  <= '0;
      sreg_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StRstLo: begin
          if (rcnt_q == RW'(RESX_LOW - 1)) begin
            RESX    <= 1'b1;
            rcnt_q  <= '0;
            state_q <= StRstWait;
          end else begin
            rcnt_q <= rcnt_q + 1'b1;
          end
        end
        StRstWait: begin
          if (rcnt_q == RW'(RESX_WAIT - 1)) begin
            rcnt_q  <= '0;
            ready_q <= 1'b1;
            BUSY    <= 1'b0;
            state_q <= StIdle;
          end else begin
            rcnt_q <= rcnt_q + 1'b1;
          end
        end
        StIdle, StHold: begin
          if (state_q == StIdle && INIT) begin
            RESX    <= 1'b0;
            ready_q <= 1'b0;
            BUSY    <= 1'b1;
            rcnt_q  <= '0;
            state_q <= StRstLo;
          end else if (accept) begin
            CSX     <= 1'b0;
            SCL     <= 1'b0;
            SDA     <= frame[NB-1];
            sreg_q  <= frame;
            last_q  <= TX_LAST;
            ready_q <= 1'b0;
            BUSY    <= 1'b1;
            dcnt_q  <= '0;
            bcnt_q  <= '0;
            state_q <= StShift;
          end
        end
        StShift: begin
          if (dcnt_q == DW'(CLK_DIV - 1)) begin
            dcnt_q <= '0;
            if (!SCL) begin
              SCL <= 1'b1;
            end else if (bcnt_q == BW'(NB - 1)) begin
              SCL     <= 1'b0;
              ready_q <= 1'b1;
              if (last_q) begin
                CSX     <= 1'b1;
                SDA     <= 1'b0;
                BUSY    <= 1'b0;
                state_q <= StIdle;
              end else begin
                state_q <= StHold;
              end
            end else begin
              // Data only moves on entry to the low phase, so it is stable at the rising edge.
              SCL    <= 1'b0;
              SDA    <= sreg_nx[NB-1];
              sreg_q <= sreg_nx;
              bcnt_q <= bcnt_q + 1'b1;
            end
          end else begin
            dcnt_q <= dcnt_q + 1'b1;
          end
        end
        default: state_q <= StRstLo;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_spi_tx.sv
// Directed bench for lcd_spi_tx: four parameterisations share reset, INIT and the data bus.
module tb_lcd_spi_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        init = 1'b0;
  logic [3:0]  valid = '0;
  logic [17:0] data18 = '0;
  logic [7:0]  data8 = '0;
  logic        dc = 1'b0;
  logic        last = 1'b0;
  logic [3:0]  ready, csx, scl, sda, resx, busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // 0: defaults, 1: 8-bit + D/C, 2: 8-bit, 3: 8-bit with CLK_DIV=3
  lcd_spi_tx u_def (
    .CLK(clk), .RST(rst), .INIT(init), .TX_VALID(valid[0]), .TX_READY(ready[0]),
    .TX_DATA(data18), .TX_DC(dc), .TX_LAST(last), .CSX(csx[0]), .SCL(scl[0]),
    .SDA(sda[0]), .RESX(resx[0]), .BUSY(busy[0])
  );
  lcd_spi_tx #(.DATA_W(8), .DC_BIT(1)) u_dc (
    .CLK(clk), .RST(rst), .INIT(init), .TX_VALID(valid[1]), .TX_READY(ready[1]),
    .TX_DATA(data8), .TX_DC(dc), .TX_LAST(last), .CSX(csx[1]), .SCL(scl[1]),
    .SDA(sda[1]), .RESX(resx[1]), .BUSY(busy[1])
  );
  lcd_spi_tx #(.DATA_W(8)) u_b8 (
    .CLK(clk), .RST(rst), .INIT(init), .TX_VALID(valid[2]), .TX_READY(ready[2]),
    .TX_DATA(data8), .TX_DC(dc), .TX_LAST(last), .CSX(csx[2]), .SCL(scl[2]),
    .SDA(sda[2]), .RESX(resx[2]), .BUSY(busy[2])
  );
  lcd_spi_tx #(.DATA_W(8), .CLK_DIV(3)) u_div3 (
    .CLK(clk), .RST(rst), .INIT(init), .TX_VALID(valid[3]), .TX_READY(ready[3]),
    .TX_DATA(data8), .TX_DC(dc), .TX_LAST(last), .CSX(csx[3]), .SCL(scl[3]),
    .SDA(sda[3]), .RESX(resx[3]), .BUSY(busy[3])
  );

  logic [17:0] wq[3];
  logic        lq[3];
  int          csx_low, rises, hi_cnt, first_rise, second_rise;
  logic [31:0] bits;
  logic        ended;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offers wq[0..n-1] on instance idx with VALID held, and records the frame seen on the pins.
  task automatic xfer(input int idx, input int n, input int limit);
    int   k = 0;
    int   pos = 0;
    logic prev_scl = 1'b0;
    logic prev_rdy;
    logic started = 1'b0;
    csx_low = 0; rises = 0; hi_cnt = 0; first_rise = -1; second_rise = -1;
    bits = '0; ended = 1'b0;
    @(negedge clk);
    data18 = wq[0]; data8 = wq[0][7:0]; last = lq[0]; valid[idx] = 1'b1;
    prev_rdy = ready[idx];
    for (int c = 0; c < limit && !ended; c++) begin
      @(negedge clk);
      if (valid[idx] && prev_rdy) begin
        k++;
        if (k < n) begin
          data18 = wq[k]; data8 = wq[k][7:0]; last = lq[k];
        end else begin
          valid[idx] = 1'b0;
        end
      end
      if (!csx[idx]) begin
        started = 1'b1;
        csx_low++;
        if (scl[idx]) hi_cnt++;
        if (scl[idx] && !prev_scl) begin
          if (rises == 0) first_rise = pos;
          else if (rises == 1) second_rise = pos;
          rises++;
          bits = {bits[30:0], sda[idx]};
        end
        pos++;
      end else if (started) begin
        ended = 1'b1;
      end
      prev_scl = scl[idx];
      prev_rdy = ready[idx];
    end
    valid[idx] = 1'b0;
  endtask

  initial begin
    // Reset sequence: RST held over exactly one rising edge.
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 7; c++) begin
      chk("rst_resx", resx[0], (c >= 4));
      chk("rst_ready", ready[0], (c >= 6));
      chk("rst_busy", busy[0], (c < 6));
      chk("rst_csx", csx[0], 1);
      chk("rst_scl", scl[0], 0);
      @(negedge clk);
    end

    // Single 18-bit word.
    wq[0] = 18'h20E31; lq[0] = 1'b1;
    xfer(0, 1, 100);
    chk("w18_end", ended, 1);
    chk("w18_csx_low", csx_low, 36);
    chk("w18_rises", rises, 18);
    chk("w18_bits", bits, 32'h20E31);
    chk("w18_first_rise", first_rise, 1);
    chk("w18_sda_after", sda[0], 0);
    chk("w18_scl_after", scl[0], 0);
    chk("w18_ready_after", ready[0], 1);

    // D/C mode, DC=0 then DC=1.
    wq[0] = 18'h2A; lq[0] = 1'b1; dc = 1'b0;
    xfer(1, 1, 100);
    chk("dc0_end", ended, 1);
    chk("dc0_rises", rises, 9);
    chk("dc0_bits", bits, 32'h02A);
    chk("dc0_csx_low", csx_low, 18);
    dc = 1'b1;
    xfer(1, 1, 100);
    chk("dc1_bits", bits, 32'h12A);
    dc = 1'b0;

    // Three-word burst with VALID held high.
    wq[0] = 18'h2C; lq[0] = 1'b0;
    wq[1] = 18'hFF; lq[1] = 1'b0;
    wq[2] = 18'h00; lq[2] = 1'b1;
    xfer(2, 3, 200);
    chk("burst_end", ended, 1);
    chk("burst_csx_low", csx_low, 50);
    chk("burst_rises", rises, 24);
    chk("burst_bits", bits, 32'h2CFF00);
    chk("burst_busy_after", busy[2], 0);

    // SCL timing with CLK_DIV=3.
    wq[0] = 18'hA5; lq[0] = 1'b1;
    xfer(3, 1, 200);
    chk("div3_end", ended, 1);
    chk("div3_csx_low", csx_low, 48);
    chk("div3_rises", rises, 8);
    chk("div3_bits", bits, 32'hA5);
    chk("div3_first_rise", first_rise, 3);
    chk("div3_second_rise", second_rise, 9);
    chk("div3_hi_cnt", hi_cnt, 24);

    // INIT and VALID together in IDLE: no accept, reset sequence reruns.
    init = 1'b1; valid[0] = 1'b1; data18 = 18'h3FFFF; last = 1'b1;
    #1;
    chk("col_ready_masked", ready[0], 0);
    @(negedge clk);
    init = 1'b0; valid[0] = 1'b0;
    chk("col_resx", resx[0], 0);
    chk("col_busy", busy[0], 1);
    chk("col_csx", csx[0], 1);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      chk("col_csx_hold", csx[0], 1);
    end
    chk("col_ready_back", ready[0], 1);
    chk("col_resx_back", resx[0], 1);

    // RST during bit 5 of a frame aborts it on the next cycle.
    data18 = 18'h3FFFF; last = 1'b1; valid[0] = 1'b1;
    @(negedge clk);
    valid[0] = 1'b0;
    chk("abort_started", csx[0], 0);
    repeat (10) @(negedge clk);
    chk("abort_pre_sda", sda[0], 1);
    chk("abort_pre_scl", scl[0], 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_csx", csx[0], 1);
    chk("abort_scl", scl[0], 0);
    chk("abort_sda", sda[0], 0);
    chk("abort_resx", resx[0], 0);
    chk("abort_ready", ready[0], 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
